seg7_scan_driver: RTL

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver_pkg.sv | 29 ++
 rtl/seg7_scan_driver_hex_to_seg7.sv | 17 +
 rtl/seg7_scan_driver.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver_pkg
// Description : Shared types, segment table and parameter limits for the
//               seven-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_scan_driver_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

    localparam int NUM_DIGITS_MIN = 1;
    localparam int NUM_DIGITS_MAX = 8;
    localparam int SCAN_DIV_MIN   = 2;
    localparam int SCAN_DIV_MAX   = 1 << 20;

    localparam seg_t SEG_OFF = 7'h7F;

    // Active-low a..g patterns, seg[6]=a down to seg[0]=g; entry 15 listed first.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h38, 7'h30, 7'h42, 7'h31,   // F E d C
        7'h60, 7'h08, 7'h04, 7'h00,   // b A 9 8
        7'h0F, 7'h20, 7'h24, 7'h4C,   // 7 6 5 4
        7'h06, 7'h12, 7'h4F, 7'h01    // 3 2 1 0
    };

endpackage : seg7_scan_driver_pkg
`default_nettype wire

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_seg7
// Description : Combinational hex nibble to active-low seven-segment decode.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_hex];

endmodule : hex_to_seg7
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Multiplexed seven-segment scan driver with frame-synchronous
//               display update. Define SEG7_LZ_BLANK_EN for leading-zero
//               blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int c_cnt_w = $clog2(SCAN_DIV);
    localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_cnt_w-1:0]    c_cnt_last = c_cnt_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_pre  = c_cnt_w'(SCAN_DIV - 2);
    localparam logic [c_idx_w-1:0]    c_idx_last = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_an_one   = NUM_DIGITS'(1);

    generate
        if ((NUM_DIGITS < NUM_DIGITS_MIN) || (NUM_DIGITS > NUM_DIGITS_MAX) ||
            (SCAN_DIV < SCAN_DIV_MIN) || (SCAN_DIV > SCAN_DIV_MAX)) begin : g_bad_params
            $error("seg7_scan_driver: NUM_DIGITS or SCAN_DIV out of range");
        end
    endgenerate

    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_idx_w-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_display;
    logic                    r_pending;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_tick;

    logic       w_cnt_last;
    logic       w_idx_last;
    logic       w_boundary;
    logic       w_tick_next;
    logic [3:0] w_digit;
    logic [6:0] w_seg_dec;
    logic [6:0] w_seg_next;

    assign w_cnt_last = (r_cnt == c_cnt_last);
    assign w_idx_last = (r_idx == c_idx_last);
    assign w_boundary = w_cnt_last && w_idx_last;
    // The cycle before a boundary always sits at the same idx, so registering
    // this lookahead makes frame_tick coincide exactly with the boundary cycle.
    assign w_tick_next = (r_cnt == c_cnt_pre) && w_idx_last;

    assign w_digit = r_display[4*r_idx +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .i_hex (w_digit),
        .o_seg (w_seg_dec)
    );

`ifdef SEG7_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] w_blank;

    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_blank
            if (k == 0) begin : g_lsd
                assign w_blank[k] = 1'b0;
            end else begin : g_upper
                assign w_blank[k] = (r_display[4*NUM_DIGITS-1:4*k] == '0);
            end
        end
    endgenerate

    assign w_seg_next = w_blank[r_idx] ? SEG_OFF : w_seg_dec;
`else
    assign w_seg_next = w_seg_dec;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_cnt_last) begin
            r_cnt <= '0;
            r_idx <= w_idx_last ? '0 : r_idx + c_idx_w'(1);
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // A load on the boundary bypasses the shadow so it is never a frame late.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_display <= '0;
            r_pending <= 1'b0;
        end else if (w_boundary) begin
            if (load) begin
                r_display <= value;
                r_pending <= 1'b0;
            end else if (r_pending) begin
                r_display <= r_shadow;
                r_pending <= 1'b0;
            end
        end else if (load) begin
            r_shadow  <= value;
            r_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg        <= SEG_OFF;
            r_an         <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_seg        <= w_seg_next;
            r_an         <= ~(c_an_one << r_idx);
            r_frame_tick <= w_tick_next;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule : seg7_scan_driver
`default_nettype wire
